// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the GCD job arbiter.
//   - GCD_WIDTH  : default operand/result width
//   - state_e    : one-hot arbiter states (same style as the core controller)
//   - sel_onehot : turns a 1-bit requester index into its 2-bit one-hot mask
package gcd_pkg;

  localparam int GCD_WIDTH = 8;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_LOAD_A = 6'b000010,
    ST_LOAD_B = 6'b000100,
    ST_RUN    = 6'b001000,
    ST_RESP   = 6'b010000,
    ST_CLEAR  = 6'b100000
  } state_e;

  function automatic logic [1:0] sel_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/gcd_rr_pick.sv
// gcd_rr_pick: combinational 2-way round-robin picker.
//   req : per-requester request bits
//   ptr : requester that wins when both request
//   gnt : one-hot grant (all zero when nobody requests)
module gcd_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Single requester wins outright; a tie goes to the pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one serial-load GCD core between two requesters.
//   clk, rst              : clock, async active-high reset
//   req_valid/req_a/req_b : per-requester job request (held until req_ack)
//   req_ack               : one-cycle pulse when a job is captured
//   rsp_valid/rsp_data/rsp_err/rsp_ready : result handshake to the owner
//   gcd_start/gcd_data    : core start strobe and serial operand bus (A then B)
//   gcd_done/gcd_result   : core completion and result
//   gcd_clear             : one-cycle core reset pulse ending every job
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = 300
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         req_ack,
  output logic [1:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  input  logic [1:0]         rsp_ready,
  output logic               gcd_start,
  output logic [WIDTH-1:0]   gcd_data,
  input  logic               gcd_done,
  input  logic [WIDTH-1:0]   gcd_result,
  output logic               gcd_clear
);

  localparam int CW = $clog2(TIMEOUT);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [1:0]       gnt;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             owner_ready;

  gcd_rr_pick u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign sel_a       = gnt[1] ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign sel_b       = gnt[1] ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  assign owner_ready = owner_q ? rsp_ready[1] : rsp_ready[0];

  // Next-state and datapath-latch decode for the job sequencer.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d = gnt[1];
          ptr_d   = ~gnt[1];
          a_d     = sel_a;
          b_d     = sel_b;
          // A zero operand would make the subtract loop spin forever.
          if ((sel_a == {WIDTH{1'b0}}) || (sel_b == {WIDTH{1'b0}})) begin
            result_d = {WIDTH{1'b0}};
            err_d    = 1'b1;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_LOAD_A;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: begin
        cnt_d   = {CW{1'b0}};
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (gcd_done) begin
          result_d = gcd_result;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          result_d = {WIDTH{1'b0}};
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        if (owner_ready) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and latch registers; reset aborts any job and re-homes the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      err_q    <= 1'b0;
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // req_ack is the only input-dependent output; masked during reset so
  // a held request is not acknowledged while the block is being cleared.
  assign req_ack   = ((state_q == ST_IDLE) && !rst) ? gnt : 2'b00;

  assign rsp_valid = (state_q == ST_RESP) ? sel_onehot(owner_q) : 2'b00;
  assign rsp_data  = (state_q == ST_RESP) ? result_q : {WIDTH{1'b0}};
  assign rsp_err   = (state_q == ST_RESP) ? err_q : 1'b0;
  assign gcd_start = (state_q == ST_LOAD_A);
  assign gcd_data  = (state_q == ST_LOAD_A) ? a_q :
                     (state_q == ST_LOAD_B) ? b_q : {WIDTH{1'b0}};
  assign gcd_clear = (state_q == ST_CLEAR);

endmodule
